// File: rtl/ex_muldiv_seq.sv
// Iterative multiply/divide sequencer for the execute stage: 32-step shift-add
// multiply or restoring divide, stalling the pipeline through BusyE until DONE.
module ex_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StartE,
  input  logic [1:0]       MdOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             AbortE,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] ResultE
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_r, state_next_s;
  logic [CW-1:0]    count_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic [WIDTH-1:0] result_r;

  logic             accept_s, div_zero_s, last_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   rem_sh_s;
  logic             no_borrow_s;
  logic [WIDTH-1:0] trial_s;
  logic [WIDTH-1:0] step_hi_s, step_lo_s, final_s, dz_result_s;

  // Accept/terminal-count decode shared by the FSM and the datapath.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && StartE && !AbortE;
    div_zero_s  = MdOpE[1] && (SrcBE == {WIDTH{1'b0}});
    last_s      = (count_r == CW'(WIDTH - 1));
    dz_result_s = MdOpE[0] ? SrcAE : {WIDTH{1'b1}};
  end

  // One iteration step: hi/lo serve as {carry,hi,lo} for multiply and {rem,quo} for divide.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    rem_sh_s    = {hi_r, lo_r[WIDTH-1]};
    // The shifted remainder can exceed WIDTH bits when B is large, so compare at full width.
    no_borrow_s = (rem_sh_s >= {1'b0, b_r});
    trial_s     = rem_sh_s[WIDTH-1:0] - b_r;
    step_hi_s   = {WIDTH{1'b0}};
    step_lo_s   = {WIDTH{1'b0}};
    if (op_r[1]) begin
      step_lo_s = {lo_r[WIDTH-2:0], no_borrow_s};
      step_hi_s = no_borrow_s ? trial_s : rem_sh_s[WIDTH-1:0];
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
    case (op_r)
      2'b00:   final_s = step_lo_s;
      2'b01:   final_s = step_hi_s;
      2'b10:   final_s = step_lo_s;
      2'b11:   final_s = step_hi_s;
      default: final_s = step_lo_s;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; abort wins over everything.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = div_zero_s ? ST_DONE : ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (AbortE) begin
          state_next_s = ST_IDLE;
        end else if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Operand latch, iteration registers and the result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r  <= {CW{1'b0}};
      op_r     <= 2'b00;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      count_r <= {CW{1'b0}};
      op_r    <= MdOpE;
      a_r     <= SrcAE;
      b_r     <= SrcBE;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= MdOpE[1] ? SrcAE : SrcBE;
      if (div_zero_s) begin
        result_r <= dz_result_s;
      end
    end else if ((state_r == ST_RUN) && !AbortE) begin
      count_r <= count_r + CW'(1);
      hi_r    <= step_hi_s;
      lo_r    <= step_lo_s;
      if (last_s) begin
        result_r <= final_s;
      end
    end
  end

  assign BusyE   = rst && (accept_s || (state_r == ST_RUN));
  assign DoneE   = (state_r == ST_DONE);
  assign ResultE = result_r;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed and random ops against a
// plain-arithmetic reference, plus abort, back-to-back and reset scenarios.
module tb_ex_muldiv_seq;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          StartE = 1'b0;
  logic          AbortE = 1'b0;
  logic [1:0]    MdOpE = 2'b00;
  logic [W-1:0]  SrcAE = '0;
  logic [W-1:0]  SrcBE = '0;
  logic          BusyE, DoneE;
  logic [W-1:0]  ResultE;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] last_exp = '0;

  ex_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .MdOpE(MdOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .AbortE(AbortE),
    .BusyE(BusyE), .DoneE(DoneE), .ResultE(ResultE)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_cycle(input logic [1:0] op, input logic [31:0] b);
    return (op[1] && b == 32'd0) ? 1 : W + 1;
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    StartE = 1'b1; AbortE = 1'b0; MdOpE = op; SrcAE = a; SrcBE = b;
  endtask

  // Inputs for the accept cycle are already driven; returns at the DONE-cycle negedge.
  task automatic wait_done(input logic [31:0] exp_res, input int exp_cyc, input string name);
    int cyc;
    bit busy_ok, seen;
    cyc = 0; busy_ok = 1'b1; seen = 1'b0;
    @(negedge clk);
    if (BusyE !== 1'b1) busy_ok = 1'b0;
    while (!seen && cyc < 45) begin
      @(posedge clk); #1;
      cyc++;
      SrcAE = $urandom; SrcBE = $urandom; MdOpE = 2'($urandom);
      @(negedge clk);
      if (DoneE === 1'b1) seen = 1'b1;
      else if (BusyE !== 1'b1) busy_ok = 1'b0;
    end
    tests++;
    if (!seen || cyc != exp_cyc) begin
      fails++; $display("FAIL %s done_cycle: got %0d (seen=%0d) want %0d", name, cyc, seen, exp_cyc);
    end
    tests++;
    if (ResultE !== exp_res) begin
      fails++; $display("FAIL %s result: got %h want %h", name, ResultE, exp_res);
    end
    tests++;
    if (BusyE !== 1'b0) begin
      fails++; $display("FAIL %s busy_in_done: got %b want 0", name, BusyE);
    end
    tests++;
    if (!busy_ok) begin
      fails++; $display("FAIL %s busy_while_running: got a low BusyE want 1", name);
    end
    StartE = 1'b0;
    last_exp = exp_res;
  endtask

  task automatic check_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    start_op(op, a, b);
    wait_done(ref_result(op, a, b), ref_cycle(op, b), name);
  endtask

  task automatic test_reset();
    StartE = 1'b1; MdOpE = 2'b00; SrcAE = 32'd3; SrcBE = 32'd4;
    #12;
    tests++;
    if (BusyE !== 1'b0 || DoneE !== 1'b0 || ResultE !== 32'd0) begin
      fails++; $display("FAIL reset_state: got busy=%b done=%b res=%h want 0/0/0", BusyE, DoneE, ResultE);
    end
    StartE = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (BusyE !== 1'b0 || DoneE !== 1'b0) begin
      fails++; $display("FAIL reset_idle: got busy=%b done=%b want 0/0", BusyE, DoneE);
    end
  endtask

  task automatic test_mul();
    check_op(2'b00, 32'd7, 32'd6, "mul_7x6");
    @(negedge clk);
    tests++;
    if (DoneE !== 1'b0 || ResultE !== 32'h0000_002A) begin
      fails++; $display("FAIL mul_after_done: got done=%b res=%h want 0/0000002a", DoneE, ResultE);
    end
    check_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    check_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
  endtask

  task automatic test_div();
    check_op(2'b10, 32'd100, 32'd7, "divu_100_7");
    check_op(2'b11, 32'd100, 32'd7, "remu_100_7");
    check_op(2'b10, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    check_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, "remu_big_divisor");
    check_op(2'b10, 32'd3, 32'd9, "divu_small");
  endtask

  task automatic test_div_zero();
    check_op(2'b10, 32'd5, 32'd0, "divu_by_zero");
    check_op(2'b11, 32'd5, 32'd0, "remu_by_zero");
  endtask

  task automatic test_back_to_back();
    check_op(2'b00, 32'd12345, 32'd678, "b2b_first");
    StartE = 1'b1; MdOpE = 2'b11; SrcAE = 32'd1000; SrcBE = 32'd33;
    wait_done(32'd10, W + 1, "b2b_second");
  endtask

  task automatic test_abort();
    logic [31:0] held;
    bit no_done;
    held = last_exp;
    no_done = 1'b1;
    start_op(2'b00, 32'd123, 32'd456);
    repeat (10) begin
      @(posedge clk); #1;
      if (DoneE !== 1'b0) no_done = 1'b0;
    end
    AbortE = 1'b1;
    @(posedge clk); #1;
    AbortE = 1'b0; StartE = 1'b0;
    #1;
    tests++;
    if (BusyE !== 1'b0 || DoneE !== 1'b0 || !no_done || ResultE !== held) begin
      fails++; $display("FAIL abort_mid_run: got busy=%b done=%b res=%h want 0/0/%h", BusyE, DoneE, ResultE, held);
    end
    StartE = 1'b1; MdOpE = 2'b10; SrcAE = 32'd9; SrcBE = 32'd3;
    wait_done(32'd3, W + 1, "divu_after_abort");
    // Abort beats start in IDLE.
    @(posedge clk); #1;
    StartE = 1'b1; AbortE = 1'b1; MdOpE = 2'b00; SrcAE = 32'd2; SrcBE = 32'd2;
    #1;
    tests++;
    if (BusyE !== 1'b0) begin
      fails++; $display("FAIL abort_priority_busy: got %b want 0", BusyE);
    end
    @(posedge clk); #1;
    StartE = 1'b0; AbortE = 1'b0;
    no_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (DoneE !== 1'b0 || BusyE !== 1'b0) no_done = 1'b0;
    end
    tests++;
    if (!no_done) begin
      fails++; $display("FAIL abort_priority_idle: got activity want idle");
    end
    // Abort during DONE still shows DoneE.
    start_op(2'b11, 32'd5, 32'd0);
    @(posedge clk); #1;
    StartE = 1'b0; AbortE = 1'b1;
    @(negedge clk);
    tests++;
    if (DoneE !== 1'b1 || ResultE !== 32'd5) begin
      fails++; $display("FAIL abort_in_done: got done=%b res=%h want 1/00000005", DoneE, ResultE);
    end
    @(posedge clk); #1;
    AbortE = 1'b0;
    @(negedge clk);
    tests++;
    if (DoneE !== 1'b0 || BusyE !== 1'b0) begin
      fails++; $display("FAIL abort_after_done: got done=%b busy=%b want 0/0", DoneE, BusyE);
    end
    last_exp = 32'd5;
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      check_op(op, a, b, $sformatf("random_%0d", i));
    end
  endtask

  task automatic test_reset_mid_run();
    bit idle_ok;
    start_op(2'b10, 32'hDEAD_BEEF, 32'd17);
    repeat (20) begin
      @(posedge clk); #1;
    end
    StartE = 1'b0;
    #2 rst = 1'b0;
    #1;
    tests++;
    if (BusyE !== 1'b0 || DoneE !== 1'b0 || ResultE !== 32'd0) begin
      fails++; $display("FAIL reset_mid_run: got busy=%b done=%b res=%h want 0/0/0", BusyE, DoneE, ResultE);
    end
    @(negedge clk); rst = 1'b1;
    idle_ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (BusyE !== 1'b0 || DoneE !== 1'b0 || ResultE !== 32'd0) idle_ok = 1'b0;
    end
    tests++;
    if (!idle_ok) begin
      fails++; $display("FAIL reset_release_idle: got activity after reset want idle");
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_abort();
    test_random();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Iterative multiply/divide sequencer attached to the execute stage. It takes the forwarded operands of a mul/div instruction sitting in E, runs a 32-step shift-add multiply or restoring divide, and holds the pipeline via a busy signal to the hazard unit until the result is ready. The result is merged into the ALU result path in the DONE cycle. It lets a single iterative unit serve every M-extension-style op without widening the single-cycle ALU.

## Interface

Parameters:
- `WIDTH`, default 32: operand/result width. Iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  the single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low: asserted when 0.
- `StartE`  in  1  the E-stage instruction is a mul/div op with valid operands.
- `MdOpE`  in  2  operation: 00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU (quotient), 11 REMU (remainder).
- `SrcAE`  in  WIDTH  forwarded operand A, the multiplicand or dividend.
- `SrcBE`  in  WIDTH  forwarded operand B, the multiplier or divisor.
- `AbortE`  in  1  synchronous kill of the E-stage instruction (FlushE from the hazard unit).
- `BusyE`  out  1  to the hazard unit: stall F/D/E and bubble M while high.
- `DoneE`  out  1  single-cycle pulse; `ResultE` is valid this cycle.
- `ResultE`  out  WIDTH  selected result, registered.

## Operation

- States are IDLE, RUN, and DONE. The state is encoded in 2 bits, plus a count register of log2(`WIDTH`)+1 bits.
- **IDLE:** `StartE`=1 and `AbortE`=0 latch `SrcAE`, `SrcBE`, `MdOpE` and clear the count.
  - DIVU/REMU with `SrcBE`=0 goes to DONE. The result is all-ones for DIVU and `SrcAE` for REMU.
  - Otherwise it goes to RUN.
- **Multiply in RUN:** use a {carry, hi, lo} accumulator, initialised with hi=0 and lo=B.
  - Each step: if lo[0]=1, hi = hi + A at `WIDTH`+1 bits, with the carry captured.
  - Then shift {carry, hi, lo} right by 1.
  - After `WIDTH` steps, {hi, lo} is the unsigned 2·`WIDTH` product. MUL selects lo; MULHU selects hi.
- **Divide in RUN:** initialise rem=0 and quo=A.
  - Each step: shift {rem, quo} left by 1, then compute trial = rem − B at `WIDTH`+1 bits.
  - If trial is non-negative: rem = trial[`WIDTH`-1:0] and quo[0]=1.
  - DIVU selects quo; REMU selects rem.
- RUN goes to DONE when the count reaches `WIDTH`−1 at that edge; the last step is performed on that edge.
- **DONE:** `DoneE`=1 and `BusyE`=0, so the pipeline advances at this edge. The state returns to IDLE unconditionally.
- `ResultE` is loaded on the edge entering DONE. It holds until the next DONE load.
- `AbortE`=1 in any state forces IDLE at the next edge and suppresses that op's `DoneE`. `ResultE` keeps its old value. `AbortE` has priority over `StartE`.
- `BusyE` = rst & ((IDLE & `StartE` & ~`AbortE`) | RUN). It is combinational, so the stall is effective in the accept cycle.
- Operands are sampled only in the IDLE accept cycle. Later changes on `SrcAE`/`SrcBE`, such as a forwarding-mux change, are ignored.

## Timing

- Reset values:
  - state = IDLE, count = 0, `ResultE` = 0, `DoneE` = 0.
  - `BusyE` is forced 0 while `rst`=0.
- Cycle numbering is relative to the accept cycle, which is cycle 0 (`BusyE`=1).
- Normal op: RUN occupies cycles 1..`WIDTH`. DONE is cycle `WIDTH`+1, which is 33 for the default. The instruction holds E for `WIDTH`+2 cycles.
- Divide-by-zero: DONE is cycle 1, so the instruction holds E for 2 cycles.
- Back-to-back mul/div: the cycle after DONE is IDLE and can accept the next `StartE` at once. There is no dead cycle beyond DONE→IDLE.
- `StartE` seen in RUN or DONE is ignored; it is the stalled instruction itself.
- Reset asserted mid-RUN takes effect immediately:
  - state goes to IDLE and `BusyE` drops to 0 asynchronously.
  - The partial result is discarded.
  - After release, nothing happens until `StartE`.
- Abort in the DONE cycle: `DoneE` is still 1 that cycle, since it is combinational from state. The next state is IDLE in either case.

## Test plan

- MUL, A=7, B=6: `BusyE`=1 for cycles 0..32; at cycle 33 `DoneE`=1 and `ResultE`=0x0000002A. `DoneE`=0 at cycle 34.
- MULHU, A=B=0xFFFFFFFF: `ResultE`=0xFFFFFFFE at cycle 33. MUL with the same operands gives 0x00000001.
- DIVU 100/7 gives `ResultE`=0x0000000E. REMU 100/7 gives 0x00000002, with `DoneE` at cycle 33. DIVU 0xFFFFFFFF/1 gives 0xFFFFFFFF.
- DIVU 5/0: `DoneE` at cycle 1 with 0xFFFFFFFF. REMU 5/0: `DoneE` at cycle 1 with 0x00000005.
- MUL started, `AbortE`=1 at cycle 10:
  - IDLE at cycle 11 with `BusyE`=0.
  - No `DoneE`, and `ResultE` unchanged.
  - A new DIVU 9/3 accepted at cycle 11 yields 0x00000003 at its cycle 33.
- `rst`→0 at cycle 20 of a DIVU: `BusyE` falls in the same cycle and `ResultE`=0. After `rst`→1 with `StartE`=0, the unit stays IDLE.
